instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns mnemonic encode requests into 32-bit MIPS instruction words and
//   writes them to consecutive word addresses of an instruction memory.
//
//   Handshakes:
//     - A request is accepted on a rising edge where req_valid && req_ready.
//       req_ready is high only in IDLE while neither done nor full is set.
//       req_valid is not looked at outside IDLE.
//     - A memory write is held (mem_we, mem_addr, mem_wdata stable) from the
//       cycle after the accept until the cycle mem_ack is high. mem_ack is
//       ignored whenever mem_we is low.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     req_valid/req_ready   request handshake
//     op_sel                mnemonic code (0..12 valid, 13..15 invalid)
//     rs, rt, rd            register fields
//     imm, target           I-type immediate, J-type target
//     mem_we/mem_addr/
//     mem_wdata/mem_ack     instruction-memory write port
//     count                 words written since reset
//     done                  sticky, a SYSCALL word has been written
//     full                  sticky, the last address has been written
//     err                   one-cycle pulse after an invalid op_sel accept
//     state_dbg             current FSM state (debug)
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST     = '1;
  localparam logic [31:0]       SYS_WORD = 32'h0000_000C;

  state_t              state_q,     state_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     count_q,     count_d;
  logic                done_q,      done_d;
  logic                full_q,      full_d;
  logic                err_q,       err_d;

  logic [31:0] enc_word;
  logic        enc_ok;

  // Instruction encoding; unused fields are left at zero.
  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b1;
    case (op_sel)
      4'd0:  enc_word = 32'h0000_0000;                        // NOOP
      4'd1:  enc_word = {6'b100011, rs, rt, imm};             // LW
      4'd2:  enc_word = {6'b101011, rs, rt, imm};             // SW
      4'd3:  enc_word = {6'b000010, target};                  // J
      4'd4:  enc_word = {6'b000011, target};                  // JAL
      4'd5:  enc_word = {6'b000101, rs, rt, imm};             // BNE
      4'd6:  enc_word = {6'b001110, rs, rt, imm};             // XORI
      4'd7:  enc_word = {6'b001000, rs, rt, imm};             // ADDI
      4'd8:  enc_word = {6'b000000, rs, 15'b0, 6'b001000};    // JR
      4'd9:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100000}; // ADD
      4'd10: enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100010}; // SUB
      4'd11: enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b101010}; // SLT
      4'd12: enc_word = SYS_WORD;                             // SYSCALL
      default: enc_ok = 1'b0;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE) && !done_q && !full_q;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    done_d      = done_q;
    full_d      = full_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (enc_ok) begin
            mem_wdata_d = enc_word;
            mem_we_d    = 1'b1;
            state_d     = ST_WRITE;
          end else begin
            // Rejected request: flag it, nothing else moves.
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
          count_d  = count_q + (ADDR_W+1)'(1);
          state_d  = ST_IDLE;
          // The address saturates at the last word instead of wrapping.
          if (mem_addr_q == LAST) begin
            full_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
          // Only SYSCALL encodes to this exact word.
          if (mem_wdata_q == SYS_WORD) begin
            done_d  = 1'b1;
            state_d = ST_STOP;
          end
        end
      end
      default: begin
        // ST_STOP: leaves only through reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      done_q      <= done_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign done      = done_q;
  assign full      = full_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
